// File: rtl/mpu_pkg.sv
// Shared widths, state encodings and saturation bounds for the matrix-unit PE.
package mpu_pkg;

  localparam int MPU_A_W   = 8;
  localparam int MPU_W_W   = 8;
  localparam int MPU_ACC_W = 24;

  // Widest accumulator the bound helper can describe.
  localparam int MPU_BOUND_W = 64;

  typedef enum logic {
    PE_IDLE = 1'b0,
    PE_RUN  = 1'b1
  } pe_state_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Clamp value for an acc_w-bit accumulator. The result is zero-extended to
  // MPU_BOUND_W; callers keep the low acc_w bits (the signed minimum is then
  // the two's-complement pattern 100..0).
  function automatic logic [MPU_BOUND_W-1:0] sat_bound(input int   acc_w,
                                                       input logic is_signed,
                                                       input logic upper);
    logic [MPU_BOUND_W-1:0] one;
    logic [MPU_BOUND_W-1:0] res;
    one = {{(MPU_BOUND_W-1){1'b0}}, 1'b1};
    if (is_signed) begin
      if (upper) res = (one << (acc_w - 1)) - one;
      else       res = one << (acc_w - 1);
    end else begin
      if (upper) res = (one << acc_w) - one;
      else       res = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational saturating adder, two's complement or unsigned per i_signed.
import mpu_pkg::*;

module mac_sat_add #(
  parameter int ACC_W = MPU_ACC_W
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  input  logic             i_signed,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_sat
);

  localparam logic [MPU_BOUND_W-1:0] L_SMAX = sat_bound(ACC_W, 1'b1, 1'b1);
  localparam logic [MPU_BOUND_W-1:0] L_SMIN = sat_bound(ACC_W, 1'b1, 1'b0);
  localparam logic [MPU_BOUND_W-1:0] L_UMAX = sat_bound(ACC_W, 1'b0, 1'b1);

  logic [ACC_W:0] w_sum_ext;
  logic           w_ext_a;
  logic           w_ext_b;

  assign w_ext_a   = i_signed & i_a[ACC_W-1];
  assign w_ext_b   = i_signed & i_b[ACC_W-1];
  assign w_sum_ext = {w_ext_a, i_a} + {w_ext_b, i_b};

  // One extra bit catches both the unsigned carry and the signed overflow;
  // in signed mode the extra bit is the true sign and picks the clamp side.
  always_comb begin
    o_sum = w_sum_ext[ACC_W-1:0];
    o_sat = 1'b0;
    if (i_signed) begin
      if (w_sum_ext[ACC_W] != w_sum_ext[ACC_W-1]) begin
        o_sat = 1'b1;
        o_sum = w_sum_ext[ACC_W] ? L_SMIN[ACC_W-1:0] : L_SMAX[ACC_W-1:0];
      end
    end else if (w_sum_ext[ACC_W]) begin
      o_sat = 1'b1;
      o_sum = L_UMAX[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/mac_pe.sv
// Weight-stationary MAC cell for the int8 systolic array: shadow-buffered
// weight, saturating accumulator and a one-deep result slot with valid/ready.
//
// pe_state_t
//   state     | meaning
//   PE_IDLE   | no accumulation open; accumulator holds zero
//   PE_RUN    | at least one non-last beat accumulated
// out_state_t
//   state     | meaning
//   OUT_EMPTY | no result pending
//   OUT_FULL  | acc_out/acc_sat hold a result awaiting acc_ready
import mpu_pkg::*;

module mac_pe #(
  parameter int A_W   = MPU_A_W,
  parameter int W_W   = MPU_W_W,
  parameter int ACC_W = MPU_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [A_W-1:0]   a_in,
  input  logic             a_valid_in,
  input  logic             a_last_in,
  input  logic             signed_mode,
  output logic [A_W-1:0]   a_out,
  output logic             a_valid_out,
  output logic             a_last_out,
  input  logic [W_W-1:0]   w_in,
  input  logic             w_load,
  input  logic             w_swap,
  output logic [W_W-1:0]   w_out,
  output logic             w_load_out,
  output logic             w_swap_out,
  input  logic             acc_clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_sat,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf_err
);

  localparam int P_W = A_W + W_W;

  logic [A_W-1:0]   r_a_out;
  logic             r_a_valid_out;
  logic             r_a_last_out;
  logic [W_W-1:0]   r_w_out;
  logic             r_w_load_out;
  logic             r_w_swap_out;

  logic [W_W-1:0]   r_w_act;
  logic [W_W-1:0]   r_w_shd;

  pe_state_t        r_pe_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_sat;

  out_state_t       r_out_state;
  logic [ACC_W-1:0] r_acc_out;
  logic             r_acc_sat;
  logic             r_acc_valid;
  logic             r_ovf_err;

  logic [P_W-1:0]   w_a_ext;
  logic [P_W-1:0]   w_w_ext;
  logic [P_W-1:0]   w_prod;
  logic [ACC_W-1:0] w_prod_acc;
  logic             w_fresh;
  logic [ACC_W-1:0] w_acc_base;
  logic             w_sat_base;
  logic [ACC_W-1:0] w_sum;
  logic             w_add_sat;
  logic             w_sat_new;
  logic             w_done;
  logic             w_xfer;

  // Both operands widened to the full product width with mode-dependent
  // extension; the truncated P_W-bit product is then exact in either mode,
  // so a single multiplier serves signed and unsigned beats.
  assign w_a_ext = {{W_W{signed_mode & a_in[A_W-1]}}, a_in};
  assign w_w_ext = {{A_W{signed_mode & r_w_act[W_W-1]}}, r_w_act};
  assign w_prod  = w_a_ext * w_w_ext;

  generate
    if (ACC_W > P_W) begin : g_prod_ext
      assign w_prod_acc = {{(ACC_W-P_W){signed_mode & w_prod[P_W-1]}}, w_prod};
    end else begin : g_prod_same
      assign w_prod_acc = w_prod;
    end
  endgenerate

  // A clear (or an idle accumulator) makes this beat start from zero.
  assign w_fresh    = acc_clear | (r_pe_state == PE_IDLE);
  assign w_acc_base = w_fresh ? '0 : r_acc;
  assign w_sat_base = w_fresh ? 1'b0 : r_sat;

  mac_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .i_a      (w_acc_base),
    .i_b      (w_prod_acc),
    .i_signed (signed_mode),
    .o_sum    (w_sum),
    .o_sat    (w_add_sat)
  );

  assign w_sat_new = w_sat_base | w_add_sat;
  assign w_done    = a_valid_in & a_last_in;
  assign w_xfer    = r_acc_valid & acc_ready;

  // East/south neighbour feeds: plain one-cycle delay, never stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_out       <= '0;
      r_a_valid_out <= 1'b0;
      r_a_last_out  <= 1'b0;
      r_w_out       <= '0;
      r_w_load_out  <= 1'b0;
      r_w_swap_out  <= 1'b0;
    end else begin
      r_a_out       <= a_in;
      r_a_valid_out <= a_valid_in;
      r_a_last_out  <= a_last_in;
      r_w_out       <= w_in;
      r_w_load_out  <= w_load;
      r_w_swap_out  <= w_swap;
    end
  end

  // Shadow/active weight pair; a simultaneous load and swap promotes the old
  // shadow while capturing the new weight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_act <= '0;
      r_w_shd <= '0;
    end else begin
      if (w_swap) r_w_act <= r_w_shd;
      if (w_load) r_w_shd <= w_in;
    end
  end

  // Accumulator FSM: completion hands the sum to the slot and re-arms at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pe_state <= PE_IDLE;
      r_acc      <= '0;
      r_sat      <= 1'b0;
    end else if (a_valid_in) begin
      if (a_last_in) begin
        r_pe_state <= PE_IDLE;
        r_acc      <= '0;
        r_sat      <= 1'b0;
      end else begin
        r_pe_state <= PE_RUN;
        r_acc      <= w_sum;
        r_sat      <= w_sat_new;
      end
    end else if (acc_clear) begin
      r_pe_state <= PE_IDLE;
      r_acc      <= '0;
      r_sat      <= 1'b0;
    end
  end

  // One-deep result slot; a completion that finds it full and not draining
  // is lost and latched in ovf_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_state <= OUT_EMPTY;
      r_acc_out   <= '0;
      r_acc_sat   <= 1'b0;
      r_acc_valid <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else if (w_done) begin
      if ((r_out_state == OUT_EMPTY) || w_xfer) begin
        r_out_state <= OUT_FULL;
        r_acc_out   <= w_sum;
        r_acc_sat   <= w_sat_new;
        r_acc_valid <= 1'b1;
      end else begin
        r_ovf_err   <= 1'b1;
      end
    end else if (w_xfer) begin
      r_out_state <= OUT_EMPTY;
      r_acc_valid <= 1'b0;
    end
  end

  assign a_out       = r_a_out;
  assign a_valid_out = r_a_valid_out;
  assign a_last_out  = r_a_last_out;
  assign w_out       = r_w_out;
  assign w_load_out  = r_w_load_out;
  assign w_swap_out  = r_w_swap_out;
  assign acc_out     = r_acc_out;
  assign acc_sat     = r_acc_sat;
  assign acc_valid   = r_acc_valid;
  assign ovf_err     = r_ovf_err;

endmodule
